// File: rtl/sys_bus_pkg.sv
// Shared types and helpers for the sys_bus interconnect.
package sys_bus_pkg;

  // Wide enough for any practical host/device count; fields are zero-extended.
  localparam int unsigned MaxIdxW = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefaultHostIdxW = idx_width(1);
  localparam int unsigned DefaultDevIdxW  = idx_width(1);

  typedef struct packed {
    logic [MaxIdxW-1:0] host_idx;
    logic [MaxIdxW-1:0] dev_idx;
    logic               valid;
    logic               unmapped;
  } rsp_sel_t;

endpackage

// File: rtl/sys_bus_arb.sv
// Fixed-priority arbiter: lowest requesting index wins; one-hot grant plus binary index.
module sys_bus_arb
  import sys_bus_pkg::*;
#(
  parameter int unsigned N    = 1,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan downwards so the lowest requester is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bus.sv
// Single-cycle shared bus: fixed-priority host arbitration, base/mask device decode, response steering.
// Optional SVA checks are compiled in when SYS_BUS_ASSERT_EN is defined.
module sys_bus
  import sys_bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys_n,

  input  logic                    host_req_i     [NrHosts],
  output logic                    host_gnt_o     [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
  input  logic                    host_we_i      [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
  output logic                    host_rvalid_o  [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
  output logic                    host_err_o     [NrHosts],

  output logic                    device_req_o   [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
  output logic                    device_we_o    [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
  input  logic                    device_rvalid_i[NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
  input  logic                    device_err_i   [NrDevices],

  input  logic [AddressWidth-1:0] cfg_device_addr_base[NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask[NrDevices]
);

  localparam int unsigned HostIdxW = idx_width(NrHosts);
  localparam int unsigned DevIdxW  = idx_width(NrDevices);

  logic [NrHosts-1:0]      host_req_vec;
  logic [NrHosts-1:0]      arb_req;
  logic [NrHosts-1:0]      arb_gnt;
  logic [HostIdxW-1:0]     win_idx;
  logic                    win_valid;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [DataWidth/8-1:0]  win_be;
  logic [DataWidth-1:0]    win_wdata;
  logic [NrDevices-1:0]    dev_match;
  logic [NrDevices-1:0]    dev_req_vec;
  logic [DevIdxW-1:0]      dev_idx;
  logic                    dev_hit;
  rsp_sel_t                rsp_sel_d, rsp_sel_q;
  logic                    rsp_rvalid;
  logic                    rsp_err;
  logic [DataWidth-1:0]    rsp_rdata;

  // Requests are masked while in reset so every output sits at zero.
  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_req
    assign host_req_vec[gi] = host_req_i[gi];
    assign arb_req[gi]      = host_req_i[gi] & rst_sys_n;
    assign host_gnt_o[gi]   = arb_gnt[gi];
  end

  sys_bus_arb #(
    .N    (NrHosts),
    .IdxW (HostIdxW)
  ) u_arb (
    .req_i   (arb_req),
    .gnt_o   (arb_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (arb_gnt[h]) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev_match
    assign dev_match[gi] = (win_addr & cfg_device_addr_mask[gi]) == cfg_device_addr_base[gi];
  end

  always_comb begin
    dev_idx = '0;
    dev_hit = 1'b0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (dev_match[d]) begin
        dev_idx = DevIdxW'(d);
        dev_hit = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev_out
    assign dev_req_vec[gi]    = win_valid & dev_hit & (dev_idx == DevIdxW'(gi));
    assign device_req_o[gi]   = dev_req_vec[gi];
    assign device_addr_o[gi]  = win_addr;
    assign device_we_o[gi]    = win_we;
    assign device_be_o[gi]    = win_be;
    assign device_wdata_o[gi] = win_wdata;
  end

  always_comb begin
    rsp_sel_d       = rsp_sel_q;
    rsp_sel_d.valid = win_valid;
    if (win_valid) begin
      rsp_sel_d.host_idx = MaxIdxW'(win_idx);
      rsp_sel_d.dev_idx  = MaxIdxW'(dev_idx);
      rsp_sel_d.unmapped = ~dev_hit;
    end else begin
      rsp_sel_d.unmapped = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rsp_sel_q <= '0;
    end else begin
      rsp_sel_q <= rsp_sel_d;
    end
  end

  // Only the registered device is listened to, so stray rvalids never leak through.
  always_comb begin
    rsp_rvalid = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    if (rsp_sel_q.valid) begin
      if (rsp_sel_q.unmapped) begin
        rsp_rvalid = 1'b1;
        rsp_err    = 1'b1;
      end else begin
        for (int d = 0; d < NrDevices; d++) begin
          if (rsp_sel_q.dev_idx == MaxIdxW'(d)) begin
            rsp_rvalid = device_rvalid_i[d];
            rsp_err    = device_rvalid_i[d] & device_err_i[d];
            rsp_rdata  = device_rvalid_i[d] ? device_rdata_i[d] : '0;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_rsp
    logic sel;
    assign sel               = rsp_sel_q.host_idx == MaxIdxW'(gi);
    assign host_rvalid_o[gi] = sel & rsp_rvalid;
    assign host_err_o[gi]    = sel & rsp_err;
    assign host_rdata_o[gi]  = sel ? rsp_rdata : '0;
  end

`ifdef SYS_BUS_ASSERT_EN
  logic [NrDevices-1:0] dev_req_d, dev_req_q;
  assign dev_req_d = dev_req_vec;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      dev_req_q <= '0;
    end else begin
      dev_req_q <= dev_req_d;
    end
  end

  a_single_decode: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    win_valid |-> $onehot0(dev_match));

  a_req_known: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    !$isunknown(host_req_vec));

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_rvalid_chk
    a_rvalid_after_req: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
      device_rvalid_i[gi] |-> dev_req_q[gi]);
  end
`endif

endmodule

// File: tb/tb_sys_bus.sv
// Scoreboard bench for sys_bus: 2 hosts, 3 devices (RAM, SimCtrl, Timer).
module tb_sys_bus;

  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk_sys;
  logic          rst_sys_n;
  logic          host_req_i     [NH];
  logic          host_gnt_o     [NH];
  logic [AW-1:0] host_addr_i    [NH];
  logic          host_we_i      [NH];
  logic [DW/8-1:0] host_be_i    [NH];
  logic [DW-1:0] host_wdata_i   [NH];
  logic          host_rvalid_o  [NH];
  logic [DW-1:0] host_rdata_o   [NH];
  logic          host_err_o     [NH];
  logic          device_req_o   [ND];
  logic [AW-1:0] device_addr_o  [ND];
  logic          device_we_o    [ND];
  logic [DW/8-1:0] device_be_o  [ND];
  logic [DW-1:0] device_wdata_o [ND];
  logic          device_rvalid_i[ND];
  logic [DW-1:0] device_rdata_i [ND];
  logic          device_err_i   [ND];
  logic [AW-1:0] cfg_base       [ND];
  logic [AW-1:0] cfg_mask       [ND];

  logic [DW-1:0] dev_val     [ND];
  logic          dev_err_cfg [ND];

  typedef struct {
    int            host;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  sys_bus #(
    .NrDevices    (ND),
    .NrHosts      (NH),
    .DataWidth    (DW),
    .AddressWidth (AW)
  ) dut (
    .clk_sys              (clk_sys),
    .rst_sys_n            (rst_sys_n),
    .host_req_i           (host_req_i),
    .host_gnt_o           (host_gnt_o),
    .host_addr_i          (host_addr_i),
    .host_we_i            (host_we_i),
    .host_be_i            (host_be_i),
    .host_wdata_i         (host_wdata_i),
    .host_rvalid_o        (host_rvalid_o),
    .host_rdata_o         (host_rdata_o),
    .host_err_o           (host_err_o),
    .device_req_o         (device_req_o),
    .device_addr_o        (device_addr_o),
    .device_we_o          (device_we_o),
    .device_be_o          (device_be_o),
    .device_wdata_o       (device_wdata_o),
    .device_rvalid_i      (device_rvalid_i),
    .device_rdata_i       (device_rdata_i),
    .device_err_i         (device_err_i),
    .cfg_device_addr_base (cfg_base),
    .cfg_device_addr_mask (cfg_mask)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Device model: every device answers exactly one cycle after its request.
  always @(posedge clk_sys) begin
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] <= device_req_o[d];
      device_err_i[d]    <= device_req_o[d] & dev_err_cfg[d];
      device_rdata_i[d]  <= device_req_o[d] ? dev_val[d] : '0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare responses against the queue, then check grant/decode and push expectations.
  initial begin
    forever begin
      exp_t e;
      bit   has_e;
      int   win;
      int   dev;
      @(negedge clk_sys);
      if (!rst_sys_n) begin
        exp_q.delete();
        for (int h = 0; h < NH; h++) begin
          check("rst_gnt", host_gnt_o[h], 0);
          check("rst_rvalid", host_rvalid_o[h], 0);
          check("rst_err", host_err_o[h], 0);
          check("rst_rdata", host_rdata_o[h], 0);
        end
        for (int d = 0; d < ND; d++) begin
          check("rst_dreq", device_req_o[d], 0);
          check("rst_daddr", device_addr_o[d], 0);
        end
      end else begin
        has_e = exp_q.size() > 0;
        if (has_e) e = exp_q.pop_front();
        for (int h = 0; h < NH; h++) begin
          bit mine;
          mine = has_e && (e.host == h);
          check("rvalid", host_rvalid_o[h], mine);
          check("err", host_err_o[h], mine ? e.err : 1'b0);
          check("rdata", host_rdata_o[h], mine ? e.rdata : 32'h0);
        end
        if (has_e)
          $display("txn rsp host=%0d rdata=0x%08h err=%0d", e.host, e.rdata, e.err);

        win = -1;
        for (int h = NH - 1; h >= 0; h--) if (host_req_i[h]) win = h;
        for (int h = 0; h < NH; h++) check("gnt", host_gnt_o[h], win == h);
        if (win >= 0) begin
          dev = -1;
          for (int d = ND - 1; d >= 0; d--)
            if ((host_addr_i[win] & cfg_mask[d]) == cfg_base[d]) dev = d;
          for (int d = 0; d < ND; d++) begin
            check("dreq", device_req_o[d], dev == d);
            check("daddr", device_addr_o[d], host_addr_i[win]);
            check("dwe", device_we_o[d], host_we_i[win]);
            check("dbe", device_be_o[d], host_be_i[win]);
            check("dwdata", device_wdata_o[d], host_wdata_i[win]);
          end
          e.host  = win;
          e.rdata = (dev < 0) ? 32'h0 : dev_val[dev];
          e.err   = (dev < 0) ? 1'b1 : dev_err_cfg[dev];
          exp_q.push_back(e);
          $display("txn req host=%0d addr=0x%08h we=%0d dev=%0d", win, host_addr_i[win], host_we_i[win], dev);
        end else begin
          for (int d = 0; d < ND; d++) check("dreq_idle", device_req_o[d], 0);
        end
      end
    end
  end

  task automatic set_host(input int h, input logic req, input logic [AW-1:0] addr,
                          input logic we, input logic [DW-1:0] wdata);
    host_req_i[h]   = req;
    host_addr_i[h]  = addr;
    host_we_i[h]    = we;
    host_be_i[h]    = 4'hF;
    host_wdata_i[h] = wdata;
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  logic [AW-1:0] addr_tbl [6];

  initial begin
    rst_sys_n = 1'b0;
    cfg_base[0] = 32'h0020_0000; cfg_mask[0] = ~32'h001F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    dev_val[0] = 32'hDEAD_BEEF;
    dev_val[1] = 32'h1111_0001;
    dev_val[2] = 32'h2222_0002;
    for (int d = 0; d < ND; d++) dev_err_cfg[d] = 1'b0;
    addr_tbl[0] = 32'h0020_0010; addr_tbl[1] = 32'h0002_0004;
    addr_tbl[2] = 32'h0003_03FC; addr_tbl[3] = 32'h1000_0000;
    addr_tbl[4] = 32'h003F_FFFC; addr_tbl[5] = 32'h0002_0400;
    set_host(1, 1'b0, '0, 1'b0, '0);
    // A request held during reset must not produce a grant.
    set_host(0, 1'b1, 32'h0020_0004, 1'b0, '0);
    repeat (3) step();
    set_host(0, 1'b0, '0, 1'b0, '0);
    rst_sys_n = 1'b1;
    step();

    // RAM read
    set_host(0, 1'b1, 32'h0020_0004, 1'b0, '0); step();
    set_host(0, 1'b0, '0, 1'b0, '0); step();
    // SimCtrl write
    set_host(0, 1'b1, 32'h0002_0000, 1'b1, 32'h41); step();
    set_host(0, 1'b0, '0, 1'b0, '0); step();
    // Unmapped from host 1
    set_host(1, 1'b1, 32'h1000_0000, 1'b0, '0); step();
    set_host(1, 1'b0, '0, 1'b0, '0); step();
    // Timer with device error
    dev_err_cfg[2] = 1'b1;
    set_host(0, 1'b1, 32'h0003_0008, 1'b0, '0); step();
    set_host(0, 1'b0, '0, 1'b0, '0); step();
    dev_err_cfg[2] = 1'b0;
    // Contention: host 0 first, host 1 keeps requesting and wins next
    set_host(0, 1'b1, 32'h0020_0008, 1'b0, '0);
    set_host(1, 1'b1, 32'h0003_0004, 1'b1, 32'hCAFE);
    step();
    set_host(0, 1'b0, '0, 1'b0, '0); step();
    set_host(1, 1'b0, '0, 1'b0, '0); step();

    // Random back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      for (int h = 0; h < NH; h++)
        set_host(h, 1'($urandom_range(0, 1)), addr_tbl[$urandom_range(0, 5)],
                 1'($urandom_range(0, 1)), $urandom);
      for (int d = 0; d < ND; d++) dev_err_cfg[d] = 1'($urandom_range(0, 1));
      step();
    end
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, '0, 1'b0, '0);
    for (int d = 0; d < ND; d++) dev_err_cfg[d] = 1'b0;
    step(); step();

    // Reset one cycle after a request discards the response
    set_host(0, 1'b1, 32'h0020_0004, 1'b0, '0); step();
    set_host(0, 1'b0, '0, 1'b0, '0);
    rst_sys_n = 1'b0;
    step(); step();
    rst_sys_n = 1'b1;
    step(); step(); step();

    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
